// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt controller: synchronises and edge-detects request lines,
// arbitrates pending against in-service level, and drives the PC redirect on entry/return.
module interrupt_controller #(
   parameter int unsigned NUM_IRQ = 3,
   parameter int unsigned ADDR_W = 32,
   parameter logic [ADDR_W-1:0] VEC_BASE = 32'h0000_1000,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               sti,
   input  logic               cli,
   input  logic               mret,
   input  logic [ADDR_W-1:0]  pc_next,
   output logic               int_take,
   output logic [ADDR_W-1:0]  int_vector,
   output logic               int_ret,
   output logic [ADDR_W-1:0]  ret_pc,
   output logic               ie,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] in_service,
   output logic [CNT_W-1:0]   int_count
);

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [NUM_IRQ-1:0] sync1, sync2, prev, armed, irq_edge;
   logic [1:0]         primed;
   logic [ADDR_W-1:0]  epc [NUM_IRQ];
   logic [IDX_W-1:0]   win, cur;
   logic               cur_valid;
   logic [NUM_IRQ-1:0] win_mask, cur_mask, pending_d, in_service_d;

   // A line is armed only once it has been seen low after the synchroniser is primed,
   // so a level held high across reset release never counts as an edge.
   assign irq_edge = sync2 & ~prev & armed;

   always_comb begin
      win       = '0;
      cur       = '0;
      cur_valid = 1'b0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (pending[i]) win = IDX_W'(i);
         if (in_service[i]) begin
            cur       = IDX_W'(i);
            cur_valid = 1'b1;
         end
      end
   end

   assign win_mask   = NUM_IRQ'(1) << win;
   assign cur_mask   = NUM_IRQ'(1) << cur;
   assign int_take   = ie & (|pending) & (!cur_valid | (win > cur)) & !cli & !mret;
   assign int_vector = VEC_BASE + (ADDR_W'(win) << 2);
   assign int_ret    = mret & (|in_service);
   assign ret_pc     = epc[cur];

   always_comb begin
      pending_d    = (pending & ~(int_take ? win_mask : '0)) | irq_edge;
      in_service_d = in_service;
      if (int_take) in_service_d = in_service_d | win_mask;
      if (int_ret)  in_service_d = in_service_d & ~cur_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         armed      <= '0;
         primed     <= '0;
         ie         <= 1'b0;
         pending    <= '0;
         in_service <= '0;
         int_count  <= '0;
         for (int i = 0; i < int'(NUM_IRQ); i++) epc[i] <= '0;
      end else begin
         sync1      <= irq_in;
         sync2      <= sync1;
         prev       <= sync2;
         primed     <= {primed[0], 1'b1};
         armed      <= armed | ({NUM_IRQ{primed[1]}} & ~sync2);
         pending    <= pending_d;
         in_service <= in_service_d;
         if (cli)      ie <= 1'b0;
         else if (sti) ie <= 1'b1;
         if (int_take) begin
            epc[win]  <= pc_next;
            int_count <= int_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Prioritised, nestable interrupt controller for the single-cycle RV32 core.
- Synchronises and edge-detects external request lines, latches them as pending, and arbitrates against the in-service level and the global enable.
- The global enable is set and cleared by the decoder's STI/CLI strobes.
- Drives the PC-redirect mux with the vector address on entry and with the saved EPC on return (mret).
- Sits beside the PC register and takes decoded strobes from the control unit.

Parameters:
- NUM_IRQ, 3: number of request lines; higher index = higher priority.
- ADDR_W, 32: PC / vector width.
- VEC_BASE, 32'h0000_1000: vector for line i is VEC_BASE + 4*i.
- CNT_W, 16: width of the taken-interrupt counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- irq_in  in  NUM_IRQ  raw asynchronous request lines (e.g. board buttons)
- sti  in  1  decoded set-global-enable strobe, one instruction
- cli  in  1  decoded clear-global-enable strobe
- mret  in  1  decoded return-from-interrupt strobe
- pc_next  in  ADDR_W  PC the core would load this cycle (EPC source)
- int_take  out  1  redirect PC to int_vector this cycle
- int_vector  out  ADDR_W  entry address of winning line
- int_ret  out  1  redirect PC to ret_pc this cycle (equals mret when any line is in service)
- ret_pc  out  ADDR_W  EPC of highest in-service level
- ie  out  1  global interrupt enable
- pending  out  NUM_IRQ  latched pending bits
- in_service  out  NUM_IRQ  in-service bits
- int_count  out  CNT_W  number of interrupts taken

Behaviour:
- Reset (async, any time): ie=0, pending=0, in_service=0, all EPC regs=0, sync/edge flops=0, int_count=0. Outputs int_take=0, int_ret=0, int_vector=VEC_BASE, ret_pc=0.
- Input path:
  - 2-flop synchroniser per line, then a rising-edge detector on the second flop.
  - Edge-to-pending latency is 3 clk edges after the raw rise.
  - Level-held lines raise only one request.
- Pending: bit i sets on edge_i. It clears on the cycle line i is taken. A set in the same cycle as a clear wins, so a new edge is never lost.
- Arbitration (combinational from registers):
  - win = highest i with pending[i]=1.
  - cur = highest i with in_service[i]=1, or -1 if none.
  - int_take = ie & pending!=0 & win>cur & !cli & !mret.
  - int_vector = VEC_BASE + (win<<2); truncation to ADDR_W.
- On a take edge: epc[win]<=pc_next, in_service[win]<=1, pending[win]<=0, int_count<=int_count+1 (wraps at 2^CNT_W-1 -> 0).
  - ie is unchanged; nesting by a strictly higher line is allowed while ie=1.
  - Equal or lower lines wait until return.
- Return:
  - int_ret = mret & (in_service!=0); ret_pc = epc[cur].
  - On that edge in_service[cur]<=0.
  - mret with in_service=0 has no effect: int_ret=0 and no state change.
- ie update: sti -> ie<=1; cli -> ie<=0; both asserted -> cli wins. A new ie value affects arbitration from the next cycle.
- Simultaneous events:
  - mret and a takeable pending in the same cycle: return first, take is re-evaluated next cycle.
  - cli in a take cycle: take suppressed.
- int_take and int_ret are never both 1.
- No handshake with the core beyond the single-cycle strobes; the core must honour the redirect in the same cycle.

Test Plan:
- Reset then pulse irq_in[0] for 5 clk with ie=0 -> pending=3'b001 after 3 edges, int_take stays 0. Then sti -> int_take=1 one cycle later with int_vector=32'h1000. With pc_next=32'h40, epc[0]=32'h40, in_service=3'b001, pending=0, int_count=1.
- In service of line 0, pulse irq_in[2] -> take with int_vector=32'h1008 and in_service=3'b101. mret -> int_ret=1, ret_pc = EPC saved at line-2 entry, in_service=3'b001. Second mret -> ret_pc=32'h40, in_service=0.
- In service of line 1, pulse irq_in[0] -> no take, pending=3'b001 held. After mret, line 0 is taken the following cycle.
- Edges on lines 0 and 1 in the same cycle with ie=1 -> line 1 taken first (vector 32'h1004), line 0 stays pending.
- cli and sti in the same cycle -> ie=0. cli in the cycle a take is due -> int_take=0 and pending retained. mret with no line in service -> int_ret=0 and state unchanged.
- Assert rst mid-ISR (in_service=3'b010, int_count=5) -> all outputs return to reset values immediately without waiting for clk. irq_in held high across reset release does not raise a request until it falls and rises again.
